// File: rtl/booth_mult32_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package booth_mult32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } booth_op_t;

  localparam logic [5:0] ITER_LAST = 6'd31;

  // Radix-2 Booth recoding of {Q[0], q_1}.
  function automatic booth_op_t booth_recode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cbadder32.sv
// 32-bit carry-bypass adder: 4-bit ripple blocks whose carry-in skips the
// block when every bit position propagates.
module cbadder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic        c;
  logic        rc;
  logic        p;
  logic        p_all;
  int unsigned idx;

  always_comb begin
    c     = cin;
    rc    = 1'b0;
    p     = 1'b0;
    p_all = 1'b0;
    idx   = 0;
    sum   = '0;
    for (int unsigned blk = 0; blk < 8; blk++) begin
      rc    = c;
      p_all = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        idx      = blk * 4 + i;
        p        = a[idx] ^ b[idx];
        sum[idx] = p ^ rc;
        rc       = (a[idx] & b[idx]) | (p & rc);
        p_all    = p_all & p;
      end
      // Full-propagate block: forward the incoming carry directly.
      c = p_all ? c : rc;
    end
    cout = c;
  end

endmodule

// File: rtl/booth_mult32.sv
// Sequential signed 32x32->64 radix-2 Booth multiplier, one iteration per
// cycle through a single cbadder32.
module booth_mult32
  import booth_mult32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  state_t      state, state_nxt;
  booth_op_t   op;
  logic [31:0] m;
  logic [32:0] acc;
  logic [31:0] q;
  logic        q_1;
  logic [5:0]  cnt;

  logic [31:0] bop;
  logic        add_cin;
  logic [31:0] sum;
  logic        cout;
  logic        s32;
  logic        accept;

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    op      = booth_recode(q[0], q_1);
    bop     = '0;
    add_cin = 1'b0;
    case (op)
      ADD: begin
        bop = m;
      end
      SUB: begin
        bop     = ~m;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  cbadder32 u_add (
    .a    (acc[31:0]),
    .b    (bop),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

  // 33rd sum bit: sign-extended operands give a sign bit of a ^ b ^ carry.
  assign s32 = acc[32] ^ bop[31] ^ cout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == ITER_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m   <= a;
        q   <= b;
        acc <= '0;
        q_1 <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= {s32, s32, sum[31:1]};
        q   <= {sum[0], q[31:1]};
        q_1 <= q[0];
        cnt <= cnt + 6'd1;
      end
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {acc[31:0], q};

endmodule

// File: tb/tb_booth_mult32.sv
// Scoreboard bench for booth_mult32: expected products queued at launch,
// compared when done pulses.
module tb_booth_mult32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic [63:0] exp_q[$];
  int unsigned n_checks;
  int unsigned n_fail;

  booth_mult32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint px;
    longint py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(ref_mul(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge that raises done.
  task automatic finish(input string tag, input int inject);
    int          cycles;
    int          busy_cnt;
    logic [63:0] exp;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      if (cycles == inject) begin
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    check_eq({tag, "_latency"}, 64'(cycles), 64'd32);
    check_eq({tag, "_busycycles"}, 64'(busy_cnt), 64'd32);
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq({tag, "_product"}, product, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    logic [63:0] held;
    held = product;
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_done"}, 64'(done), 64'd0);
    check_eq({tag, "_idle_hold"}, product, held);
  endtask

  initial begin
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(32'd3, 32'd5);
    finish("p3x5", -1);
    idle_check("p3x5");
    launch(-32'sd4, 32'd4);
    finish("m4x4", -1);
    idle_check("m4x4");
    launch(-32'sd7, -32'sd6);
    finish("m7xm6", -1);
    launch(32'h8000_0000, 32'h8000_0000);
    finish("minxmin", -1);
    check_eq("minxmin_const", product, 64'h4000_0000_0000_0000);
    launch(32'h7FFF_FFFF, 32'h8000_0000);
    finish("maxxmin", -1);
    check_eq("maxxmin_const", product, 64'hC000_0000_8000_0000);
    idle_check("maxxmin");

    // start during RUN must be ignored
    launch(32'd2, 32'd2);
    finish("ignore", 10);
    check_eq("ignore_const", product, 64'd4);
    idle_check("ignore");

    // asynchronous reset mid-run: no result, no done
    @(negedge clk);
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);

    // back-to-back: start held in DONE re-enters RUN directly
    launch(32'd6, -32'sd3);
    finish("b2b_first", -1);
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    start = 1'b1;
    exp_q.push_back(ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF));
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b_busy", 64'(busy), 64'd1);
    finish("b2b_second", -1);
    check_eq("b2b_const", product, 64'd1);
    idle_check("b2b");

    for (int x = -4; x <= 4; x++) begin
      for (int y = -4; y <= 4; y++) begin
        launch(32'(x), 32'(y));
        finish("sweep", -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
